// File: rtl/execute_stage.sv
// execute_stage -- EX pipeline stage feeding memory_stage.
//   Chooses the ALU operands and evaluates RV32I ALU ops in one cycle.
//   Runs RV32M ops on an iterative unit: a 32-step shift-add multiplier or a
//   restoring divider working on operand magnitudes, with the sign fixed up
//   at the end.
//   All EX/MEM fields are registered.
// Ports:
//   clk_i, rst_i (async, active-high)   clock and reset
//   busywait_i                          downstream stall; holds the output registers
//   flush_i                             squash; aborts a running long op
//   valid_i, rs1/rs2/pc/imm, selects    instruction and operands from ID/EX
//   alu_op_i, is_long_i, m_funct3_i     operation select
//   sidecar inputs                      passed through to the EX/MEM registers
//   ex_busy_o                           stalls upstream while a long op is accepted or running
//   *_o                                 registered EX/MEM fields
module execute_stage #(
  parameter int XLEN       = 32,
  parameter int LONG_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            busywait_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            op_a_sel_i,
  input  logic            op_b_sel_i,
  input  logic [3:0]      alu_op_i,
  input  logic            is_long_i,
  input  logic [2:0]      m_funct3_i,
  input  logic [3:0]      op_type_i,
  input  logic            reg_wb_en_i,
  input  logic [4:0]      rd_label_i,
  input  logic [1:0]      wb_sel_i,
  input  logic            is_memory_instruction_i,
  output logic            ex_busy_o,
  output logic [3:0]      op_type_o,
  output logic            reg_wb_en_o,
  output logic [4:0]      rd_label_o,
  output logic [XLEN-1:0] alu_out_o,
  output logic [1:0]      wb_sel_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic            is_memory_instruction_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            is_long_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [31:0] work_hi, work_lo;   // product {hi,lo}, or remainder/quotient
  logic [31:0] a_mag, b_mag;
  logic        sign_a, sign_b;
  logic [2:0]  funct3_l;
  logic [3:0]  l_op_type;
  logic        l_reg_wb_en;
  logic [4:0]  l_rd;
  logic [1:0]  l_wb_sel;
  logic        l_is_mem;
  logic [31:0] l_imm, l_pc, l_rs2;

  logic [31:0] op_a, op_b, alu_res;
  logic        accept, neg_a, neg_b;
  logic        load_bubble, load_short, load_long;
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [63:0] prod, prod_s;
  logic [31:0] mul_res, quo, rem, long_res;

  // Operand selection and single-cycle ALU.
  always_comb begin
    op_a = op_a_sel_i ? pc_i : rs1_data_i;
    op_b = op_b_sel_i ? imm_i : rs2_data_i;
    case (alu_op_i)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << op_b[4:0];
      4'd3:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {31'd0, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> op_b[4:0];
      4'd7:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Operand signedness by M-op: A is signed except for the unsigned ops,
  // B is unsigned for MULHSU as well.
  always_comb begin
    case (m_funct3_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        neg_a = op_a[31];
        neg_b = op_b[31];
      end
      3'd2: begin
        neg_a = op_a[31];
        neg_b = 1'b0;
      end
      default: begin
        neg_a = 1'b0;
        neg_b = 1'b0;
      end
    endcase
  end

  assign accept    = (state == IDLE) && valid_i && is_long_i && !flush_i && !busywait_i;
  assign ex_busy_o = ((state == IDLE) && valid_i && is_long_i && !flush_i) || (state == RUN);

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a flush aborts IDLE/RUN, but DONE holds an older instruction and ignores it.
  always_comb begin
    case (state)
      IDLE: begin
        if (accept) state_next = RUN;
        else        state_next = IDLE;
      end
      RUN: begin
        if (flush_i)                                 state_next = IDLE;
        else if (count == 6'(LONG_STEPS - 1))        state_next = DONE;
        else                                         state_next = RUN;
      end
      DONE: begin
        if (!busywait_i) state_next = IDLE;
        else             state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output logic: decide what the EX/MEM registers load this edge.
  always_comb begin
    load_bubble = 1'b0;
    load_short  = 1'b0;
    load_long   = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i)                    load_bubble = 1'b1;
        else if (busywait_i)            load_bubble = 1'b0;
        else if (valid_i && !is_long_i) load_short  = 1'b1;
        else                            load_bubble = 1'b1;
      end
      RUN: begin
        if (flush_i) load_bubble = 1'b1;
        else         load_bubble = 1'b0;
      end
      DONE: begin
        if (!busywait_i) load_long = 1'b1;
        else             load_long = 1'b0;
      end
      default: load_bubble = 1'b1;
    endcase
  end

  // One iteration step of the multiplier and the divider.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_mag} : 33'd0);
    div_shift = {work_hi, work_lo[31]};
    div_ge    = (div_shift >= {1'b0, b_mag});
  end

  // Sign fix-up and final result selection for the long op.
  always_comb begin
    prod    = {work_hi, work_lo};
    prod_s  = (sign_a ^ sign_b) ? (64'd0 - prod) : prod;
    mul_res = (funct3_l[1:0] == 2'd0) ? prod_s[31:0] : prod_s[63:32];
    if (b_mag == 32'd0) begin
      // Divide by zero: all-ones quotient, remainder is the dividend.
      quo = 32'hFFFF_FFFF;
      rem = sign_a ? (32'd0 - a_mag) : a_mag;
    end else begin
      quo = (sign_a ^ sign_b) ? (32'd0 - work_lo) : work_lo;
      rem = sign_a ? (32'd0 - work_hi) : work_hi;
    end
    if (funct3_l[2]) long_res = funct3_l[1] ? rem : quo;
    else             long_res = mul_res;
  end

  // Long-op operand latch, iteration registers and step counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= 6'd0; work_hi <= 32'd0; work_lo <= 32'd0;
      a_mag <= 32'd0; b_mag <= 32'd0; sign_a <= 1'b0; sign_b <= 1'b0;
      funct3_l <= 3'd0; l_op_type <= 4'd0; l_reg_wb_en <= 1'b0; l_rd <= 5'd0;
      l_wb_sel <= 2'd0; l_is_mem <= 1'b0; l_imm <= 32'd0; l_pc <= 32'd0; l_rs2 <= 32'd0;
    end else if (accept) begin
      count    <= 6'd0;
      a_mag    <= neg_a ? (32'd0 - op_a) : op_a;
      b_mag    <= neg_b ? (32'd0 - op_b) : op_b;
      sign_a   <= neg_a;
      sign_b   <= neg_b;
      funct3_l <= m_funct3_i;
      work_hi  <= 32'd0;
      // Divider shifts the dividend out of lo; multiplier shifts the multiplier out.
      if (m_funct3_i[2]) work_lo <= neg_a ? (32'd0 - op_a) : op_a;
      else               work_lo <= neg_b ? (32'd0 - op_b) : op_b;
      l_op_type <= op_type_i; l_reg_wb_en <= reg_wb_en_i; l_rd <= rd_label_i;
      l_wb_sel <= wb_sel_i; l_is_mem <= is_memory_instruction_i;
      l_imm <= imm_i; l_pc <= pc_i; l_rs2 <= rs2_data_i;
    end else if (state == RUN && !flush_i) begin
      count <= count + 6'd1;
      if (funct3_l[2]) begin
        work_hi <= div_ge ? 32'(div_shift - {1'b0, b_mag}) : div_shift[31:0];
        work_lo <= {work_lo[30:0], div_ge};
      end else begin
        work_hi <= mul_sum[32:1];
        work_lo <= {mul_sum[0], work_lo[31:1]};
      end
    end else begin
      count <= count;
    end
  end

  // EX/MEM output registers; a bubble clears every field.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || load_bubble) begin
      op_type_o <= 4'd0; reg_wb_en_o <= 1'b0; rd_label_o <= 5'd0; alu_out_o <= 32'd0;
      wb_sel_o <= 2'd0; imm_o <= 32'd0; pc_o <= 32'd0; is_memory_instruction_o <= 1'b0;
      rs2_data_o <= 32'd0; is_long_o <= 1'b0;
    end else if (load_short) begin
      op_type_o <= op_type_i; reg_wb_en_o <= reg_wb_en_i; rd_label_o <= rd_label_i;
      alu_out_o <= alu_res; wb_sel_o <= wb_sel_i; imm_o <= imm_i; pc_o <= pc_i;
      is_memory_instruction_o <= is_memory_instruction_i; rs2_data_o <= rs2_data_i;
      is_long_o <= 1'b0;
    end else if (load_long) begin
      op_type_o <= l_op_type; reg_wb_en_o <= l_reg_wb_en; rd_label_o <= l_rd;
      alu_out_o <= long_res; wb_sel_o <= l_wb_sel; imm_o <= l_imm; pc_o <= l_pc;
      is_memory_instruction_o <= l_is_mem; rs2_data_o <= l_rs2; is_long_o <= 1'b1;
    end else begin
      alu_out_o <= alu_out_o;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expected values.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busywait = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0, pc = 32'd0, imm = 32'd0;
  logic        a_sel = 1'b0, b_sel = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic        is_long = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [3:0]  op_type = 4'd0;
  logic        wb_en = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [1:0]  wb_sel = 2'd0;
  logic        is_mem = 1'b0;

  logic        ex_busy, reg_wb_en_o, is_mem_o, is_long_o;
  logic [3:0]  op_type_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_out, imm_o, pc_o, rs2_o;
  logic [1:0]  wb_sel_o;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk_i(clk), .rst_i(rst), .busywait_i(busywait), .flush_i(flush), .valid_i(valid),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .pc_i(pc), .imm_i(imm),
    .op_a_sel_i(a_sel), .op_b_sel_i(b_sel), .alu_op_i(alu_op),
    .is_long_i(is_long), .m_funct3_i(f3), .op_type_i(op_type), .reg_wb_en_i(wb_en),
    .rd_label_i(rd), .wb_sel_i(wb_sel), .is_memory_instruction_i(is_mem),
    .ex_busy_o(ex_busy), .op_type_o(op_type_o), .reg_wb_en_o(reg_wb_en_o),
    .rd_label_o(rd_o), .alu_out_o(alu_out), .wb_sel_o(wb_sel_o), .imm_o(imm_o),
    .pc_o(pc_o), .is_memory_instruction_o(is_mem_o), .rs2_data_o(rs2_o),
    .is_long_o(is_long_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic short_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic bs, input logic [31:0] im);
    valid = 1'b1; is_long = 1'b0; alu_op = op; rs1 = a; rs2 = b; b_sel = bs; imm = im;
    wb_en = 1'b1; rd = 5'd3; op_type = 4'd2;
  endtask

  // Issue one long op, wait for its result and check latency and value.
  task automatic run_long(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int n;
    valid = 1'b1; is_long = 1'b1; f3 = fn; rs1 = a; rs2 = b; a_sel = 1'b0; b_sel = 1'b0;
    wb_en = 1'b1; rd = 5'd9; op_type = 4'd5;
    #1;
    check_eq({tag, "_busy_accept"}, {31'd0, ex_busy}, 32'd1);
    tick();
    valid = 1'b0; is_long = 1'b0;
    #1;
    check_eq({tag, "_busy_run"}, {31'd0, ex_busy}, 32'd1);
    n = 1;
    while (reg_wb_en_o == 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, n, 34);
    check_eq({tag, "_result"}, alu_out, exp);
    check_eq({tag, "_is_long"}, {31'd0, is_long_o}, 32'd1);
    check_eq({tag, "_rd"}, {27'd0, rd_o}, 32'd9);
    tick();
  endtask

  initial begin
    int wb_seen;
    #2;
    check_eq("reset_alu", alu_out, 32'd0);
    check_eq("reset_flags", {27'd0, reg_wb_en_o, is_mem_o, is_long_o, ex_busy, 1'b0}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Short ALU ops: result one edge after issue.
    short_op(4'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0); tick();
    check_eq("add", alu_out, 32'd4);
    check_eq("add_wb", {27'd0, rd_o}, 32'd3);
    check_eq("add_optype", {28'd0, op_type_o}, 32'd2);
    short_op(4'd7, 32'h8000_0000, 32'd0, 1'b1, 32'd4); tick();
    check_eq("sra", alu_out, 32'hF800_0000);
    short_op(4'd1, 32'd3, 32'd5, 1'b0, 32'd0); tick();
    check_eq("sub", alu_out, 32'hFFFF_FFFE);
    short_op(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0); tick();
    check_eq("slt", alu_out, 32'd1);
    short_op(4'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0); tick();
    check_eq("sltu", alu_out, 32'd0);
    short_op(4'd6, 32'h8000_0000, 32'd0, 1'b1, 32'd36); tick();
    check_eq("srl_b40", alu_out, 32'h0800_0000);
    short_op(4'd10, 32'd1, 32'd0, 1'b1, 32'h1234_5678); tick();
    check_eq("pass_b", alu_out, 32'h1234_5678);
    short_op(4'd12, 32'd1, 32'd2, 1'b0, 32'd0); tick();
    check_eq("op12_zero", alu_out, 32'd0);
    valid = 1'b0; tick();
    check_eq("bubble_wb", {31'd0, reg_wb_en_o}, 32'd0);
    b_sel = 1'b0;

    // Long ops.
    run_long("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_long("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_long("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_long("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_long("div0",   3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF);
    run_long("rem0",   3'd6, 32'd7,         32'd0,         32'd7);
    run_long("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_long("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_long("remneg", 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_long("divneg", 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_long("divu",   3'd5, 32'd100,       32'd7,         32'd14);
    run_long("remu",   3'd7, 32'd100,       32'd7,         32'd2);

    // busywait held for 5 cycles in DONE.
    valid = 1'b1; is_long = 1'b1; f3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd9;
    tick();
    valid = 1'b0; is_long = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    busywait = 1'b1;
    #1;
    check_eq("done_busy", {31'd0, ex_busy}, 32'd0);
    wb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (reg_wb_en_o) wb_seen++;
    end
    check_eq("bw_frozen", wb_seen, 0);
    busywait = 1'b0;
    tick();
    check_eq("bw_result", alu_out, 32'd14);
    check_eq("bw_wb", {31'd0, reg_wb_en_o}, 32'd1);
    tick();

    // Flush at RUN count 10.
    valid = 1'b1; is_long = 1'b1; f3 = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
    tick();
    valid = 1'b0; is_long = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_busy", {31'd0, ex_busy}, 32'd0);
    check_eq("flush_bubble", {31'd0, reg_wb_en_o}, 32'd0);
    short_op(4'd0, 32'd10, 32'd20, 1'b0, 32'd0); tick();
    check_eq("post_flush_add", alu_out, 32'd30);
    valid = 1'b0;
    wb_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reg_wb_en_o) wb_seen++;
    end
    check_eq("flush_no_stale", wb_seen, 0);

    // Asynchronous reset mid-RUN, after a visible short result.
    short_op(4'd0, 32'd1, 32'd1, 1'b0, 32'd0); tick();
    valid = 1'b1; is_long = 1'b1; f3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7;
    tick();
    valid = 1'b0; is_long = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy", {31'd0, ex_busy}, 32'd0);
    check_eq("rst_out", alu_out | {31'd0, reg_wb_en_o}, 32'd0);
    #2 rst = 1'b0;
    wb_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reg_wb_en_o) wb_seen++;
    end
    check_eq("rst_no_stale", wb_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
